// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter: pipeline writeback over a queued multi-cycle source
// Optional trace of issued writes is compiled in with GRF_WB_TRACE_EN.
module grf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_reg,
    input  logic [31:0]   pipe_data,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [4:0]    mdu_reg,
    input  logic [31:0]   mdu_data,
    input  logic [4:0]    q_reg,
    output logic          q_busy,
    output logic [4:0]    Wreg,
    output logic [31:0]   Wdata,
    output logic          we,
    output logic [AW:0]   fifo_cnt
);

    logic [4:0]  ent_reg_q  [DEPTH];
    logic [4:0]  ent_reg_d  [DEPTH];
    logic [31:0] ent_data_q [DEPTH];
    logic [31:0] ent_data_d [DEPTH];
    logic        ent_live_q [DEPTH];
    logic        ent_live_d [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;

    logic pipe_go;
    logic pop;
    logic push;

    assign mdu_ready = (cnt_q < (AW+1)'(DEPTH));
    assign pipe_go   = pipe_we && (pipe_reg != 5'd0);
    assign pop       = !pipe_go && (cnt_q != '0);
    assign push      = mdu_valid && mdu_ready;

    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        ent_live_d = ent_live_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;

        if (pipe_go) begin
            we_d    = 1'b1;
            wreg_d  = pipe_reg;
            wdata_d = pipe_data;
            // Older queued writes to the same register would clobber the newer pipe value.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_reg_q[i] == pipe_reg) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            if (ent_live_q[rd_ptr_q]) begin
                we_d    = 1'b1;
                wreg_d  = ent_reg_q[rd_ptr_q];
                wdata_d = ent_data_q[rd_ptr_q];
            end
            ent_live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Enqueue after the kill pass so a same-edge request survives as the newest write.
        if (push) begin
            ent_reg_d[wr_ptr_q]  = mdu_reg;
            ent_data_d[wr_ptr_q] = mdu_data;
            ent_live_d[wr_ptr_q] = (mdu_reg != 5'd0);
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_live_q <= '{default: 1'b0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            ent_live_q <= ent_live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_reg_q  <= ent_reg_d;
        ent_data_q <= ent_data_d;
    end

    always_comb begin
        q_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i] && (ent_reg_q[i] == q_reg) && (q_reg != 5'd0)) begin
                q_busy = 1'b1;
            end
        end
    end

    assign Wreg     = wreg_q;
    assign Wdata    = wdata_q;
    assign we       = we_q;
    assign fifo_cnt = cnt_q;

`ifdef GRF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && we_d) begin
            $display("$%d <= %h %s", wreg_d, wdata_d, pipe_go ? "P" : "M");
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic [4:0]  q_reg;
    logic        q_busy;
    logic [4:0]  Wreg;
    logic [31:0] Wdata;
    logic        we;
    logic [2:0]  fifo_cnt;

    int checks   = 0;
    int failures = 0;

    grf_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .q_reg(q_reg), .q_busy(q_busy),
        .Wreg(Wreg), .Wdata(Wdata), .we(we), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] e;

    initial begin
        reset = 1'b0; pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0; q_reg = '0;

        // Reset dominates a pipe request
        pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h11;
        step(); step();
        check("rst_we", we, 0);
        check("rst_wreg", Wreg, 0);
        check("rst_wdata", Wdata, 0);
        check("rst_cnt", fifo_cnt, 0);
        pipe_we = 1'b0; reset = 1'b1;
        step();
        check("rst_ready", mdu_ready, 1);
        check("idle_we", we, 0);

        // Pipe path
        pipe_we = 1'b1; pipe_reg = 5'd3; pipe_data = 32'hDEADBEEF;
        step();
        check("pipe_we", we, 1);
        check("pipe_wreg", Wreg, 3);
        check("pipe_wdata", Wdata, 32'hDEADBEEF);
        pipe_reg = 5'd0; pipe_data = 32'h55;
        step();
        check("pipe0_we", we, 0);
        check("pipe0_hold", Wdata, 32'hDEADBEEF);

        // Fill to full while the pipe stalls the queue, then drain in order
        pipe_reg = 5'd20; pipe_data = 32'h20; mdu_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mdu_reg = 5'(i); mdu_data = 32'hA0 + i;
            step();
            check("fill_cnt", fifo_cnt, i);
        end
        check("full_ready", mdu_ready, 0);
        mdu_reg = 5'd5; mdu_data = 32'hA5;
        step();
        check("full_cnt", fifo_cnt, 4);
        check("full_pipe_wreg", Wreg, 20);
        pipe_we = 1'b0; mdu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_we", we, 1);
            check("drain_wreg", Wreg, i);
            check("drain_wdata", Wdata, 32'hA0 + i);
        end
        check("drain_cnt", fifo_cnt, 0);
        check("drain_ready", mdu_ready, 1);
        step();
        check("drain_idle_we", we, 0);

        // Priority stall: reg 7 waits behind three pipe writes
        q_reg = 5'd7;
        mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h77;
        pipe_we = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            pipe_reg = 5'(i); pipe_data = 32'h100 + i;
            step();
            mdu_valid = 1'b0;
            check("stall_wreg", Wreg, i);
            check("stall_wdata", Wdata, 32'h100 + i);
            check("stall_busy", q_busy, 1);
        end
        pipe_we = 1'b0;
        step();
        check("stall_pop_wreg", Wreg, 7);
        check("stall_pop_wdata", Wdata, 32'h77);
        check("stall_busy_after", q_busy, 0);
        check("stall_cnt", fifo_cnt, 0);

        // Kill: newer pipe write to 6 supersedes queued 6
        q_reg = 5'd6;
        mdu_valid = 1'b1; mdu_reg = 5'd6; mdu_data = 32'h1;
        step();
        check("kill_busy_pre", q_busy, 1);
        mdu_valid = 1'b0; pipe_we = 1'b1; pipe_reg = 5'd6; pipe_data = 32'h2;
        step();
        check("kill_busy", q_busy, 0);
        check("kill_pipe_wdata", Wdata, 32'h2);
        check("kill_cnt", fifo_cnt, 1);
        pipe_we = 1'b0;
        step();
        check("kill_pop_we", we, 0);
        check("kill_pop_wdata", Wdata, 32'h2);
        check("kill_pop_cnt", fifo_cnt, 0);

        // Same-edge enqueue is newer than the pipe write and survives
        mdu_valid = 1'b1; mdu_reg = 5'd6; mdu_data = 32'h3;
        pipe_we = 1'b1; pipe_reg = 5'd6; pipe_data = 32'h4;
        step();
        mdu_valid = 1'b0; pipe_we = 1'b0;
        check("same_wdata", Wdata, 32'h4);
        check("same_busy", q_busy, 1);
        step();
        check("same_pop_we", we, 1);
        check("same_pop_wdata", Wdata, 32'h3);

        // MDU request to $0 completes the handshake but never writes
        mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h99;
        step();
        mdu_valid = 1'b0;
        check("zero_cnt", fifo_cnt, 1);
        step();
        check("zero_we", we, 0);
        check("zero_cnt_after", fifo_cnt, 0);

        // Steady two entries with simultaneous push/pop across pointer wrap
        pipe_we = 1'b1; pipe_reg = 5'd21; pipe_data = 32'h21;
        mdu_valid = 1'b1; mdu_reg = 5'd12;
        for (int i = 0; i < 2; i++) begin
            mdu_data = 32'hB0 + i;
            exp_q.push_back(32'hB0 + i);
            step();
        end
        pipe_we = 1'b0;
        for (int i = 2; i < 12; i++) begin
            mdu_data = 32'hB0 + i;
            exp_q.push_back(32'hB0 + i);
            step();
            e = exp_q.pop_front();
            check("wrap_cnt", fifo_cnt, 2);
            check("wrap_we", we, 1);
            check("wrap_wdata", Wdata, e);
        end

        // Mid-operation reset discards three queued writes
        pipe_we = 1'b1; pipe_reg = 5'd22; mdu_data = 32'hC0;
        step();
        check("pre_rst_cnt", fifo_cnt, 3);
        mdu_valid = 1'b0; pipe_we = 1'b0; reset = 1'b0;
        step();
        check("mid_rst_cnt", fifo_cnt, 0);
        check("mid_rst_we", we, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_we", we, 0);
            check("post_rst_cnt", fifo_cnt, 0);
        end
        q_reg = 5'd12;
        check("post_rst_busy", q_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
